// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signals of the MEM-stage load/store unit.
// master = pipeline + memory side, slave = mem_access_unit.
interface mem_access_unit_if #(
  parameter int unsigned bit_width = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [1:0]           req_size;
  logic                 req_signed;
  logic [bit_width-1:0] req_addr;
  logic [bit_width-1:0] req_wdata;
  logic                 resp_valid;
  logic [bit_width-1:0] resp_rdata;
  logic                 resp_err;
  logic [bit_width-1:0] dm_addr;
  logic [bit_width-1:0] dm_data_in;
  logic                 dm_wr;
  logic [bit_width-1:0] dm_data_out;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err, dm_addr, dm_data_in, dm_wr
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err, dm_addr, dm_data_in, dm_wr
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-addressed synchronous-read data memory:
// sub-word read-modify-write stores, extended sub-word loads, misalignment errors.
module mem_access_unit #(
  parameter int unsigned bit_width  = 32,
  parameter int unsigned addr_width = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_access_unit_if.slave       bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    LOAD_RESP = 3'd2,
    RMW_MERGE = 3'd3,
    RMW_WRITE = 3'd4,
    ERR       = 3'd5
  } state_t;

  state_t               state;
  logic                 r_we;
  logic [1:0]           r_size;
  logic                 r_signed;
  logic [1:0]           r_lane;
  logic [15:0]          r_wdata;

  logic                 req_ready_q;
  logic                 resp_valid_q;
  logic                 resp_err_q;
  logic [bit_width-1:0] dm_addr_q;
  logic [bit_width-1:0] dm_data_in_q;
  logic                 dm_wr_q;

  logic                 misaligned;
  logic [bit_width-1:0] merged;
  logic [bit_width-1:0] load_ext;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic                 unused_addr_bits;

  assign misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                      (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));

  // Read word with only the addressed byte/half lane replaced by store data.
  always_comb begin
    merged = bus.dm_data_out;
    if (r_size == 2'b00)
      merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    else
      merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
  end

  // Lane selection and sign/zero extension of load data.
  always_comb begin
    byte_sel = bus.dm_data_out[{r_lane, 3'b000} +: 8];
    half_sel = bus.dm_data_out[{r_lane[1], 4'b0000} +: 16];
    case (r_size)
      2'b00:   load_ext = r_signed ? {{(bit_width-8){byte_sel[7]}}, byte_sel}
                                   : bit_width'(byte_sel);
      2'b01:   load_ext = r_signed ? {{(bit_width-16){half_sel[15]}}, half_sel}
                                   : bit_width'(half_sel);
      default: load_ext = bus.dm_data_out;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_lane       <= 2'b00;
      r_wdata      <= 16'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      dm_addr_q    <= '0;
      dm_data_in_q <= '0;
      dm_wr_q      <= 1'b0;
    end else begin
      dm_wr_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we        <= bus.req_we;
            r_size      <= bus.req_size;
            r_signed    <= bus.req_signed;
            r_lane      <= bus.req_addr[1:0];
            r_wdata     <= bus.req_wdata[15:0];
            req_ready_q <= 1'b0;
            if (misaligned) begin
              state        <= ERR;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state     <= ISSUE;
              dm_addr_q <= bit_width'(bus.req_addr[addr_width+1:2]);
              // Full-word store needs no read: write and respond in the next cycle.
              if (bus.req_we && bus.req_size[1]) begin
                dm_wr_q      <= 1'b1;
                dm_data_in_q <= bus.req_wdata;
                resp_valid_q <= 1'b1;
              end
            end
          end
        end
        ISSUE: begin
          if (r_we && r_size[1]) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
          end else if (r_we) begin
            state <= RMW_MERGE;
          end else begin
            state        <= LOAD_RESP;
            resp_valid_q <= 1'b1;
          end
        end
        RMW_MERGE: begin
          state        <= RMW_WRITE;
          dm_data_in_q <= merged;
          dm_wr_q      <= 1'b1;
          resp_valid_q <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = (state == LOAD_RESP) ? load_ext : '0;
  assign bus.dm_addr    = dm_addr_q;
  assign bus.dm_data_in = dm_data_in_q;
  assign bus.dm_wr      = dm_wr_q;

  assign unused_addr_bits = ^bus.req_addr[bit_width-1:addr_width+2];

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a byte-array
// reference model of the data memory and the load/store rules.
module tb_mem_access_unit;
  localparam int unsigned BW = 32;
  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.bit_width(BW)) bus ();
  mem_access_unit #(.bit_width(BW), .addr_width(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem [1024];
  logic [7:0]  ref_mem [4096];
  int n_checks = 0;
  int n_fail   = 0;

  // Synchronous-read data memory.
  always @(posedge clk) begin
    if (bus.dm_wr) mem[bus.dm_addr[AW-1:0]] <= bus.dm_data_in;
    bus.dm_data_out <= mem[bus.dm_addr[AW-1:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [11:0] ba);
    logic [11:0] b;
    b = {ba[11:2], 2'b00};
    return {ref_mem[b + 12'd3], ref_mem[b + 12'd2], ref_mem[b + 12'd1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [11:0] ba, input logic [1:0] size, input logic sgn);
    logic [7:0]  v;
    logic [15:0] h;
    if (size == 2'b00) begin
      v = ref_mem[ba];
      return sgn ? {{24{v[7]}}, v} : {24'h0, v};
    end else if (size == 2'b01) begin
      h = {ref_mem[ba + 12'd1], ref_mem[ba]};
      return sgn ? {{16{h[15]}}, h} : {16'h0, h};
    end
    return ref_word(ba);
  endfunction

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata);
    logic [11:0] ba;
    logic        mis, busy_ok, idle_rd_ok, err;
    int          exp_lat, exp_wr, lat, wr_cnt, nb;
    logic [31:0] exp_rd;
    ba  = addr[11:0];
    mis = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    exp_rd = 32'h0;
    exp_wr = (we && !mis) ? 1 : 0;
    if (mis)      exp_lat = 1;
    else if (!we) begin exp_lat = 2; exp_rd = ref_load(ba, size, sgn); end
    else          exp_lat = size[1] ? 1 : 3;

    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    check("ready_before_req", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);

    lat = 0; wr_cnt = 0; busy_ok = 1'b1; idle_rd_ok = 1'b1; err = 1'b0; rdata = 32'h0;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      if (bus.req_ready) busy_ok = 1'b0;
      if (bus.dm_wr) begin
        wr_cnt++;
        check("dm_addr_on_write", bus.dm_addr, 32'(ba[11:2]));
      end
      if (bus.resp_valid) begin
        lat   = k;
        err   = bus.resp_err;
        rdata = bus.resp_rdata;
      end else if (bus.resp_rdata !== 32'h0) begin
        idle_rd_ok = 1'b0;
      end
    end
    check("resp_latency", 32'(lat), 32'(exp_lat));
    check("resp_err", 32'(err), 32'(mis));
    check("resp_rdata", rdata, exp_rd);
    check("write_count", 32'(wr_cnt), 32'(exp_wr));
    check("ready_low_while_busy", 32'(busy_ok), 32'd1);
    check("rdata_zero_when_idle", 32'(idle_rd_ok), 32'd1);
    @(negedge clk);
    check("ready_after_resp", 32'(bus.req_ready), 32'd1);
    check("quiet_after_resp", {30'h0, bus.resp_valid, bus.dm_wr}, 32'h0);

    if (we && !mis) begin
      nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      for (int i = 0; i < nb; i++) ref_mem[12'(ba + 12'(i))] = wdata[8*i +: 8];
    end
    check("mem_word", mem[ba[11:2]], ref_word(ba));
  endtask

  logic [31:0] rd;
  logic [31:0] raddr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp", {30'h0, bus.resp_valid, bus.resp_err}, 32'h0);
    check("rst_rdata", bus.resp_rdata, 32'h0);
    check("rst_dm_wr", 32'(bus.dm_wr), 32'd0);
    check("rst_dm_addr", bus.dm_addr, 32'h0);
    check("rst_dm_data_in", bus.dm_data_in, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Directed scenarios
    do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h11223344, rd);
    do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd);
    check("plan_word_load", rd, 32'h11223344);
    do_req(1'b1, 2'b00, 1'b0, 32'h15, 32'h123456AA, rd);
    do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd);
    check("plan_after_byte_store", rd, 32'h1122AA44);
    do_req(1'b0, 2'b00, 1'b1, 32'h15, 32'h0, rd);
    check("plan_signed_byte", rd, 32'hFFFFFFAA);
    do_req(1'b0, 2'b00, 1'b0, 32'h15, 32'h0, rd);
    check("plan_unsigned_byte", rd, 32'h000000AA);
    do_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, rd);
    check("plan_signed_half_pos", rd, 32'h00001122);
    do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000BEEF, rd);
    do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd);
    check("plan_after_half_store", rd, 32'hBEEFAA44);
    do_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, rd);
    check("plan_signed_half_neg", rd, 32'hFFFFBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, rd);
    do_req(1'b1, 2'b01, 1'b0, 32'h15, 32'h0000CAFE, rd);
    check("plan_mem_after_misaligned", mem[5], 32'hBEEFAA44);
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_1014, 32'hA5A5_0F0F, rd);
    check("plan_addr_wrap", mem[5], 32'hA5A5_0F0F);

    // Reset during RMW_MERGE abandons the write
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = 32'h14; bus.req_wdata = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_dm_wr", 32'(bus.dm_wr), 32'd0);
    check("midrst_ready", 32'(bus.req_ready), 32'd1);
    check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    bus.req_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("midrst_held_dm_wr", 32'(bus.dm_wr), 32'd0);
      check("midrst_held_resp", 32'(bus.resp_valid), 32'd0);
    end
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mem_unchanged", mem[5], ref_word(12'h014));
    check("midrst_ready_after", 32'(bus.req_ready), 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd);
    check("midrst_load_after", rd, 32'hA5A5_0F0F);

    // Randomized traffic over a small address window to force lane collisions
    for (int n = 0; n < 300; n++) begin
      raddr = 32'(($urandom_range(0, 3) << 12) | $urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) raddr = $urandom();
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             raddr, $urandom(), rd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
